// File: rtl/alu_pkg.sv
// Shared constants for the ALU control decoder and its mul/div issue sequencer.
// ALU codes are 4-bit here and zero-extended to CTRL_W at the decoder output.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct3[2] separates the divide/remainder group from the multiplies.
    function automatic logic md_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational ALUop/funct decode to ALU code, illegal flag and M-op marker.
// Shared with the single-cycle core, so it carries no state.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int CTRL_W   = 4,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0]        ALUop,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic              op5,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              is_md
);

    logic [3:0] w_code;

    always_comb begin
        w_code  = ALU_ADD;
        illegal = 1'b0;
        case (ALUop)
            ALUOP_MEM:    w_code = ALU_ADD;
            ALUOP_BRANCH: w_code = ALU_SUB;
            ALUOP_ARITH: begin
                case (funct3)
                    3'b000: w_code = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: w_code = ALU_SLL;
                    3'b010: w_code = ALU_SLT;
                    3'b011: w_code = ALU_SLTU;
                    3'b100: w_code = ALU_XOR;
                    // srai/srli share funct7_5 with sra/srl, so op5 is ignored here.
                    3'b101: w_code = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: w_code = ALU_OR;
                    default: w_code = ALU_AND;
                endcase
            end
            default: begin
                w_code  = ALU_ILL;
                illegal = 1'b1;
            end
        endcase
    end

    assign is_md    = ENABLE_M && (ALUop == ALUOP_ARITH) && op5 && funct7_0;
    assign alu_ctrl = CTRL_W'(w_code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// ID/EX ALU control stage: registers the decode and sequences M ops through a
// fixed-latency mul/div unit, stalling the front end while one is in flight.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int CTRL_W   = 4,
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [1:0]        ALUop,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic              op5,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              in_ready_o,
    output logic              valid_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              illegal_o,
    output logic              md_start_o,
    output logic [2:0]        md_op_o,
    output logic              md_done_o,
    output logic              md_abort_o,
    output logic              busy_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic              r_illegal;
    logic              r_md_start;
    logic [2:0]        r_md_op;
    logic              r_md_done;
    logic              r_md_abort;
    logic              r_busy;

    logic [CTRL_W-1:0] w_dec_ctrl;
    logic              w_dec_illegal;
    logic              w_dec_md;
    logic              w_accept;
    logic [CNT_W-1:0]  w_lat_m1;

    alu_op_decode #(
        .CTRL_W   (CTRL_W),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .ALUop    (ALUop),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .funct7_0 (funct7_0),
        .op5      (op5),
        .alu_ctrl (w_dec_ctrl),
        .illegal  (w_dec_illegal),
        .is_md    (w_dec_md)
    );

    assign in_ready_o = (r_state == ST_IDLE) & ~stall_i;
    assign w_accept   = valid_i & in_ready_o & ~flush_i;
    assign w_lat_m1   = md_is_div(funct3) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_alu_ctrl <= '0;
            r_illegal  <= 1'b0;
            r_md_start <= 1'b0;
            r_md_op    <= 3'b000;
            r_md_done  <= 1'b0;
            r_md_abort <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // Pulses default low every cycle, so a stall can never stretch them.
            r_md_start <= 1'b0;
            r_md_done  <= 1'b0;
            r_md_abort <= 1'b0;
            if (flush_i) begin
                r_md_abort <= (r_state == ST_BUSY);
                r_state    <= ST_IDLE;
                r_valid    <= 1'b0;
                r_busy     <= 1'b0;
                r_cnt      <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept && w_dec_md) begin
                            r_md_start <= 1'b1;
                            r_md_op    <= funct3;
                            r_alu_ctrl <= CTRL_W'(ALU_ADD);
                            r_illegal  <= 1'b0;
                            r_valid    <= 1'b0;
                            r_cnt      <= w_lat_m1;
                            r_state    <= ST_BUSY;
                            r_busy     <= 1'b1;
                        end else if (w_accept) begin
                            r_alu_ctrl <= w_dec_ctrl;
                            r_illegal  <= w_dec_illegal;
                            r_valid    <= 1'b1;
                        end else if (!stall_i) begin
                            r_valid    <= 1'b0;
                        end
                    end
                    ST_BUSY: begin
                        if (r_cnt == '0) begin
                            r_md_done <= 1'b1;
                            r_valid   <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!stall_i) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign valid_o    = r_valid;
    assign alu_ctrl_o = r_alu_ctrl;
    assign illegal_o  = r_illegal;
    assign md_start_o = r_md_start;
    assign md_op_o    = r_md_op;
    assign md_done_o  = r_md_done;
    assign md_abort_o = r_md_abort;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: an M-enabled instance and an ENABLE_M=0 instance share
// stimulus; both are compared each cycle against a cycle-count reference model.
module tb_alu_ctrl_seq;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [1:0] ALUop = 2'b00;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic       funct7_0 = 1'b0;
    logic       op5 = 1'b0;
    logic       stall_i = 1'b0;
    logic       flush_i = 1'b0;

    logic       in_ready_o, valid_o, illegal_o, md_start_o, md_done_o, md_abort_o, busy_o;
    logic [3:0] alu_ctrl_o;
    logic [2:0] md_op_o;

    logic       in_ready_nm, valid_nm, illegal_nm, md_start_nm, md_done_nm, md_abort_nm, busy_nm;
    logic [3:0] alu_ctrl_nm;
    logic [2:0] md_op_nm;

    alu_ctrl_seq #(.CTRL_W(4), .ENABLE_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ALUop(ALUop), .funct3(funct3),
        .funct7_5(funct7_5), .funct7_0(funct7_0), .op5(op5), .stall_i(stall_i),
        .flush_i(flush_i), .in_ready_o(in_ready_o), .valid_o(valid_o),
        .alu_ctrl_o(alu_ctrl_o), .illegal_o(illegal_o), .md_start_o(md_start_o),
        .md_op_o(md_op_o), .md_done_o(md_done_o), .md_abort_o(md_abort_o), .busy_o(busy_o)
    );

    alu_ctrl_seq #(.CTRL_W(4), .ENABLE_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut_nm (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ALUop(ALUop), .funct3(funct3),
        .funct7_5(funct7_5), .funct7_0(funct7_0), .op5(op5), .stall_i(stall_i),
        .flush_i(flush_i), .in_ready_o(in_ready_nm), .valid_o(valid_nm),
        .alu_ctrl_o(alu_ctrl_nm), .illegal_o(illegal_nm), .md_start_o(md_start_nm),
        .md_op_o(md_op_nm), .md_done_o(md_done_nm), .md_abort_o(md_abort_nm), .busy_o(busy_nm)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: an in-flight M op is described by its accept cycle and latency.
    int         cyc = 0;
    bit         m_active = 1'b0;
    int         m_t0 = 0;
    int         m_lat = 0;
    logic       e_valid = 0, e_ill = 0, e_start = 0, e_done = 0, e_abort = 0;
    logic [3:0] e_ctrl = 0;
    logic [2:0] e_mdop = 0;
    logic       n_valid = 0, n_ill = 0;
    logic [3:0] n_ctrl = 0;

    // Returns {illegal, code} from the architectural op table.
    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f75, input logic o5);
        logic [3:0] tbl [8];
        logic [3:0] code;
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (op == 2'd3) return {1'b1, 4'hF};
        if (op == 2'd0) return 5'd0;
        if (op == 2'd1) return 5'd1;
        code = tbl[f3];
        if (f3 == 3'd0 && o5 && f75) code = 4'd1;
        if (f3 == 3'd5 && f75) code = 4'd9;
        return {1'b0, code};
    endfunction

    task automatic model_reset();
        m_active = 0; e_valid = 0; e_ill = 0; e_start = 0; e_done = 0; e_abort = 0;
        e_ctrl = 0; e_mdop = 0; n_valid = 0; n_ill = 0; n_ctrl = 0;
    endtask

    // Called just after a falling edge: drive inputs, predict, clock, compare.
    task automatic step(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic f75, input logic f70, input logic o5,
                        input logic st, input logic fl);
        logic [4:0] d;
        bit         md;
        valid_i = v; ALUop = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
        op5 = o5; stall_i = st; flush_i = fl;
        #1;
        chk("in_ready", in_ready_o, !m_active && !st);
        chk("in_ready_nm", in_ready_nm, !st);
        d  = ref_dec(op, f3, f75, o5);
        md = (op == 2'd2) && o5 && f70;
        e_start = 0; e_done = 0; e_abort = 0;
        if (fl) begin
            e_abort  = m_active && (cyc <= m_t0 + m_lat);
            m_active = 0;
            e_valid  = 0;
        end else if (!m_active) begin
            if (v && !st && md) begin
                m_active = 1; m_t0 = cyc; m_lat = f3[2] ? DIV_LAT : MUL_LAT;
                e_start = 1; e_mdop = f3; e_ctrl = 4'd0; e_ill = 0; e_valid = 0;
            end else if (v && !st) begin
                e_ctrl = d[3:0]; e_ill = d[4]; e_valid = 1;
            end else if (!st) begin
                e_valid = 0;
            end
        end else if (cyc + 1 == m_t0 + m_lat + 1) begin
            e_done = 1; e_valid = 1;
        end else if (cyc > m_t0 + m_lat && !st) begin
            m_active = 0; e_valid = 0;
        end
        if (fl) n_valid = 0;
        else if (v && !st) begin n_ctrl = d[3:0]; n_ill = d[4]; n_valid = 1; end
        else if (!st) n_valid = 0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("valid", valid_o, e_valid);
        if (e_valid) begin
            chk("alu_ctrl", alu_ctrl_o, e_ctrl);
            chk("illegal", illegal_o, e_ill);
        end
        chk("md_start", md_start_o, e_start);
        chk("md_done", md_done_o, e_done);
        chk("md_abort", md_abort_o, e_abort);
        chk("busy", busy_o, m_active);
        if (m_active) chk("md_op", md_op_o, e_mdop);
        chk("valid_nm", valid_nm, n_valid);
        if (n_valid) begin
            chk("alu_ctrl_nm", alu_ctrl_nm, n_ctrl);
            chk("illegal_nm", illegal_nm, n_ill);
        end
        chk("md_start_nm", md_start_nm, 1'b0);
        chk("busy_nm", busy_nm, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_ctrl", alu_ctrl_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_md_start", md_start_o, 0);
        chk("rst_md_op", md_op_o, 0);
        chk("rst_md_done", md_done_o, 0);
        chk("rst_md_abort", md_abort_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid_nm", valid_nm, 0);
        chk("rst_busy_nm", busy_nm, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    int done_cnt;

    initial begin
        @(negedge clk);
        do_reset();

        // Full decode sweep, back-to-back accepts.
        for (int op = 0; op < 4; op++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int f75 = 0; f75 < 2; f75++)
                    for (int o5 = 0; o5 < 2; o5++) begin
                        step(1, 2'(op), 3'(f3), 1'(f75), 0, 1'(o5), 0, 0);
                        if (op == 2 && f3 == 5 && f75 == 1) chk("sweep_sra", alu_ctrl_o, 4'b1001);
                        if (op == 3) chk("sweep_ill", {illegal_o, alu_ctrl_o}, 5'h1F);
                    end

        // MUL: start at cycle 1, done at cycle 3.
        step(1, 2'd2, 3'd0, 0, 1, 1, 0, 0);
        chk("nm_mul_as_add", alu_ctrl_nm, 4'b0000);
        idle_steps(5);

        // DIV with stall held across the done cycle.
        done_cnt = 0;
        step(1, 2'd2, 3'd4, 0, 1, 1, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            step(0, 2'd0, 3'd0, 0, 0, 0, (k >= 30 && k <= 38), 0);
            if (md_done_o) done_cnt++;
            if (k == 36) chk("div_valid_held", valid_o, 1);
        end
        chk("div_done_count", done_cnt, 1);

        // Flush in the fifth cycle of a DIV.
        done_cnt = 0;
        step(1, 2'd2, 3'd5, 0, 1, 1, 0, 0);
        idle_steps(4);
        step(0, 2'd0, 3'd0, 0, 0, 0, 0, 1);
        chk("flush_abort", md_abort_o, 1);
        for (int k = 0; k < 40; k++) begin
            step(0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
            if (md_done_o) done_cnt++;
        end
        chk("flush_no_done", done_cnt, 0);

        // Reset in the middle of a DIV: no done, no abort afterwards.
        step(1, 2'd2, 3'd6, 0, 1, 1, 0, 0);
        idle_steps(3);
        do_reset();
        idle_steps(40);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 700; i++) begin
            if (i == 350) do_reset();
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
